// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program over 8N1 UART, writes it into
// instruction memory as little-endian words, then releases the core from reset.
//
// Receiver states:
//   state    | meaning
//   RX_IDLE  | line idle, waiting for a falling edge
//   RX_START | timing to mid start bit to reject glitches
//   RX_DATA  | sampling 8 data bits, LSB first
//   RX_STOP  | sampling stop bit, emit byte or flag framing error
// Loader states:
//   state    | meaning
//   LD_LEN   | first word is the program length N
//   LD_DATA  | writing program words, index 0..N-1
//   LD_DONE  | program loaded, core running, UART ignored
module uart_program_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int MAX_WORDS    = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        uart_rx,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst,
    output logic        loading,
    output logic [31:0] words_loaded,
    output logic        frame_err
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_FULL = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_HALF = BW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    // LD_DONE is the only state with bit 1 set, so core_rst/loading come straight off a flop.
    typedef enum logic [1:0] {LD_LEN = 2'b00, LD_DATA = 2'b01, LD_DONE = 2'b10} ld_state_t;

    logic            rx_meta, rx_sync;
    rx_state_t       rx_state, rx_nxt;
    logic [BW-1:0]   baud_cnt, baud_nxt;
    logic [2:0]      bit_cnt, bit_nxt;
    logic [7:0]      rx_shift, shift_nxt;
    logic            byte_valid, byte_valid_nxt;
    logic            frame_err_nxt;

    logic [1:0]      byte_cnt;
    logic [23:0]     word_buf;
    logic            word_cmp;
    logic [31:0]     word_full;
    logic            word_done;
    logic [31:0]     n_words;
    ld_state_t       ld_state, ld_nxt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state   <= RX_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_nxt;
            baud_cnt   <= baud_nxt;
            bit_cnt    <= bit_nxt;
            rx_shift   <= shift_nxt;
            byte_valid <= byte_valid_nxt;
            frame_err  <= frame_err_nxt;
        end
    end

    always_comb begin
        rx_nxt         = rx_state;
        baud_nxt       = baud_cnt;
        bit_nxt        = bit_cnt;
        shift_nxt      = rx_shift;
        byte_valid_nxt = 1'b0;
        frame_err_nxt  = frame_err;
        case (rx_state)
            RX_IDLE: begin
                if (!rx_sync) begin
                    rx_nxt   = RX_START;
                    baud_nxt = BAUD_HALF;
                end
            end
            RX_START: begin
                if (baud_cnt == '0) begin
                    if (!rx_sync) begin
                        rx_nxt   = RX_DATA;
                        baud_nxt = BAUD_FULL;
                        bit_nxt  = 3'd0;
                    end else begin
                        rx_nxt = RX_IDLE;
                    end
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            RX_DATA: begin
                if (baud_cnt == '0) begin
                    shift_nxt = {rx_sync, rx_shift[7:1]};
                    baud_nxt  = BAUD_FULL;
                    bit_nxt   = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) rx_nxt = RX_STOP;
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            RX_STOP: begin
                if (baud_cnt == '0) begin
                    if (rx_sync) byte_valid_nxt = 1'b1;
                    else         frame_err_nxt  = 1'b1;
                    rx_nxt = RX_IDLE;
                end else begin
                    baud_nxt = baud_cnt - BW'(1);
                end
            end
            default: rx_nxt = RX_IDLE;
        endcase
    end

    assign word_cmp  = byte_valid && (byte_cnt == 2'd3);
    assign word_full = {rx_shift, word_buf};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            word_buf <= '0;
        end else if (byte_valid) begin
            case (byte_cnt)
                2'd0:    word_buf[7:0]   <= rx_shift;
                2'd1:    word_buf[15:8]  <= rx_shift;
                2'd2:    word_buf[23:16] <= rx_shift;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    always_comb begin
        ld_nxt = ld_state;
        case (ld_state)
            LD_LEN:  if (word_done) ld_nxt = (n_words == 32'd0) ? LD_DONE : LD_DATA;
            LD_DATA: if (word_done && words_loaded == n_words) ld_nxt = LD_DONE;
            LD_DONE: ld_nxt = LD_DONE;
            default: ld_nxt = LD_LEN;
        endcase
    end

    // words_loaded doubles as the write index: both advance on every data word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_state     <= LD_LEN;
            word_done    <= 1'b0;
            n_words      <= '0;
            imem_we      <= 1'b0;
            imem_addr    <= '0;
            imem_wdata   <= '0;
            words_loaded <= '0;
        end else begin
            ld_state  <= ld_nxt;
            word_done <= word_cmp;
            imem_we   <= 1'b0;
            if (word_cmp) begin
                if (ld_state == LD_LEN) begin
                    n_words <= word_full;
                end else if (ld_state == LD_DATA) begin
                    if (words_loaded < 32'(MAX_WORDS)) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= {words_loaded[29:0], 2'b00};
                        imem_wdata <= word_full;
                    end
                    words_loaded <= words_loaded + 32'd1;
                end
            end
        end
    end

    assign core_rst = ~ld_state[1];
    assign loading  = ~ld_state[1];

endmodule

// File: tb/tb_uart_program_loader.sv
// Directed + randomized bench for uart_program_loader; two instances share the
// serial stream, one with a tiny memory so overflow words are exercised.
module tb_uart_program_loader;

    localparam int CPB  = 8;
    localparam int MAX0 = 4096;
    localparam int MAX1 = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic uart_rx = 1'b1;

    logic        we0, crst0, load0, fe0;
    logic [31:0] addr0, wdata0, wl0;
    logic        we1, crst1, load1, fe1;
    logic [31:0] addr1, wdata1, wl1;

    always #5 clk = ~clk;

    uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAX0)) u0 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .imem_we(we0), .imem_addr(addr0), .imem_wdata(wdata0),
        .core_rst(crst0), .loading(load0), .words_loaded(wl0), .frame_err(fe0)
    );

    uart_program_loader #(.CLKS_PER_BIT(CPB), .MAX_WORDS(MAX1)) u1 (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .imem_we(we1), .imem_addr(addr1), .imem_wdata(wdata1),
        .core_rst(crst1), .loading(load1), .words_loaded(wl1), .frame_err(fe1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: byte stream in, expected memory writes and status out.
    logic [31:0] exp_a0[$], exp_d0[$], exp_a1[$], exp_d1[$];
    int unsigned m_cnt;
    logic [31:0] m_word, m_n, m_idx;
    bit          m_started, m_done, m_ferr;

    function automatic void model_reset();
        m_cnt = 0; m_word = '0; m_n = '0; m_idx = '0;
        m_started = 0; m_done = 0; m_ferr = 0;
        exp_a0.delete(); exp_d0.delete(); exp_a1.delete(); exp_d1.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b, input bit good);
        if (!good) begin
            m_ferr = 1;
        end else if (!m_done) begin
            m_word[8*m_cnt +: 8] = b;
            m_cnt++;
            if (m_cnt == 4) begin
                m_cnt = 0;
                if (!m_started) begin
                    m_started = 1;
                    m_n = m_word;
                    if (m_n == 0) m_done = 1;
                end else begin
                    if (m_idx < MAX0) begin exp_a0.push_back(m_idx * 4); exp_d0.push_back(m_word); end
                    if (m_idx < MAX1) begin exp_a1.push_back(m_idx * 4); exp_d1.push_back(m_word); end
                    m_idx++;
                    if (m_idx == m_n) m_done = 1;
                end
            end
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input bit good);
        model_byte(b, good);
        @(negedge clk) uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = good;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk) rst = 1'b0;
        #1;
        chk({tag, "_rst_core_rst"}, crst0, 1);
        chk({tag, "_rst_loading"}, load0, 1);
        chk({tag, "_rst_words"}, wl0, 0);
        chk({tag, "_rst_we"}, we0, 0);
        chk({tag, "_rst_ferr"}, fe0, 0);
        chk({tag, "_rst_words_small"}, wl1, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_final(input string tag);
        repeat (4) @(negedge clk);
        chk({tag, "_pending_writes"}, exp_a0.size(), 0);
        chk({tag, "_pending_writes_small"}, exp_a1.size(), 0);
        chk({tag, "_words_loaded"}, wl0, m_idx);
        chk({tag, "_words_loaded_small"}, wl1, m_idx);
        chk({tag, "_core_rst"}, crst0, !m_done);
        chk({tag, "_loading"}, load0, !m_done);
        chk({tag, "_core_rst_small"}, crst1, !m_done);
        chk({tag, "_loading_small"}, load1, !m_done);
        chk({tag, "_frame_err"}, fe0, m_ferr);
        chk({tag, "_frame_err_small"}, fe1, m_ferr);
    endtask

    // Every write strobe must match the next expected write, in order.
    always @(negedge clk) begin
        if (rst) begin
            if (we0) begin
                if (exp_a0.size() == 0) chk("unexpected_write", we0, 0);
                else begin
                    chk("write_addr", addr0, exp_a0.pop_front());
                    chk("write_data", wdata0, exp_d0.pop_front());
                    chk("write_while_loading", load0, 1);
                end
            end
            if (we1) begin
                if (exp_a1.size() == 0) chk("unexpected_write_small", we1, 0);
                else begin
                    chk("write_addr_small", addr1, exp_a1.pop_front());
                    chk("write_data_small", wdata1, exp_d1.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] n;
        bit          seen;
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_we", we0, 0);
        chk("reset_addr", addr0, 0);
        chk("reset_wdata", wdata0, 0);
        chk("reset_words", wl0, 0);
        chk("reset_ferr", fe0, 0);
        chk("reset_core_rst", crst0, 1);
        chk("reset_loading", load0, 1);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Single-word program, with release timing checked against the write pulse.
        send_word(32'd1);
        send_byte(8'h13, 1); send_byte(8'h05, 1); send_byte(8'hA0, 1);
        fork
            send_byte(8'h00, 1);
            begin
                seen = 0;
                for (int c = 0; c < 300 && !seen; c++) begin
                    @(negedge clk);
                    if (we0) seen = 1;
                end
                if (!seen) chk("t1_write_timeout", we0, 1);
                else begin
                    chk("t1_core_rst_during_write", crst0, 1);
                    @(negedge clk);
                    chk("t1_core_rst_after", crst0, 0);
                    chk("t1_loading_after", load0, 0);
                    chk("t1_words_after", wl0, 1);
                end
            end
        join
        check_final("t1");

        do_reset("t2");
        send_word(32'd3);
        send_word(32'h11111111);
        send_word(32'h22222222);
        send_word(32'h33333333);
        check_final("t2");

        do_reset("t3");
        send_word(32'd0);
        check_final("t3_len0");
        send_byte(8'hFF, 1);
        check_final("t3_ignored");

        do_reset("t4");
        @(negedge clk) uart_rx = 1'b0;
        repeat (2) @(negedge clk);
        uart_rx = 1'b1;
        repeat (40) @(negedge clk);
        chk("t4_glitch_ferr", fe0, 0);
        send_byte(8'hA5, 0);
        chk("t4_bad_stop_ferr", fe0, 1);
        send_word(32'd1);
        send_word(32'hDEADBEEF);
        check_final("t4");

        do_reset("t5");
        send_word(32'd2);
        send_word(32'hCAFEF00D);
        send_byte(8'hAA, 1); send_byte(8'hBB, 1);
        chk("t5_words_before_abort", wl0, 1);
        do_reset("t5_abort");
        send_word(32'd2);
        send_word($urandom);
        send_word($urandom);
        check_final("t5_reload");

        for (int it = 0; it < 3; it++) begin
            do_reset("rnd");
            n = $urandom_range(1, 5);
            send_word(n);
            for (int w = 0; w < int'(n); w++) send_word($urandom);
            check_final("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
